keypad_emulator: RTL and testbench

KEYPAD_EMULATOR -- requirements
Module: keypad_emulator

---
 rtl/keypad_emulator.sv | 170 +++++++++++++++++
 tb/tb_keypad_emulator.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_emulator.sv
// Keypad contact emulator: presents one closed key to a row/column matrix scanner
// with optional make/break bounce, a timed hold and a released-contact gap.
module keypad_emulator #(
   parameter int TICK_DIV       = 100,
   parameter int GAP_CYCLES     = 100000,
   parameter int BOUNCE_PERIOD  = 50,
   parameter int BOUNCE_TOGGLES = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [3:0]  req_key,
   input  logic [15:0] req_hold,
   input  logic        abort,
   input  logic [3:0]  keypad_col,
   output logic [3:0]  keypad_row,
   output logic        pressed,
   output logic        busy,
   output logic        done
);

   localparam int CNT_MAX = (GAP_CYCLES > BOUNCE_PERIOD) ? GAP_CYCLES : BOUNCE_PERIOD;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int TICK_W  = $clog2(TICK_DIV + 1);
   localparam int PH_LAST = (BOUNCE_TOGGLES > 0) ? 2 * BOUNCE_TOGGLES - 1 : 0;
   localparam int PH_W    = $clog2(PH_LAST + 2);

   localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0]  BP_LOAD   = CNT_W'(BOUNCE_PERIOD - 1);
   localparam logic [TICK_W-1:0] TICK_LOAD = TICK_W'(TICK_DIV - 1);
   localparam logic [PH_W-1:0]   PH_END    = PH_W'(PH_LAST);

   typedef enum logic [2:0] {IDLE, BOUNCE_IN, HOLD, BOUNCE_OUT, GAP} state_t;

   state_t             state;
   logic               contact;
   logic [3:0]         key_q;
   logic [15:0]        hold_q;
   logic [15:0]        hold_cnt;
   logic [TICK_W-1:0]  tick_cnt;
   logic [CNT_W-1:0]   cnt;
   logic [PH_W-1:0]    ph;

   // Hold counts remaining ticks minus one; a zero request behaves as one tick.
   function automatic logic [15:0] hold_load(input logic [15:0] h);
      return (h == 16'd0) ? 16'd0 : h - 16'd1;
   endfunction

   always_ff @(posedge clk) begin
      if (rst && state == IDLE && req_valid) begin
         key_q  <= req_key;
         hold_q <= hold_load(req_hold);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         contact  <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         cnt      <= '0;
         tick_cnt <= '0;
         hold_cnt <= '0;
         ph       <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  busy    <= 1'b1;
                  contact <= 1'b1;
                  ph      <= '0;
                  if (BOUNCE_TOGGLES > 0) begin
                     state <= BOUNCE_IN;
                     cnt   <= BP_LOAD;
                  end else begin
                     state    <= HOLD;
                     tick_cnt <= TICK_LOAD;
                     hold_cnt <= hold_load(req_hold);
                  end
               end
            end
            BOUNCE_IN: begin
               if (abort) begin
                  state   <= GAP;
                  contact <= 1'b0;
                  cnt     <= GAP_LOAD;
               end else if (cnt == '0) begin
                  if (ph == PH_END) begin
                     state    <= HOLD;
                     contact  <= 1'b1;
                     tick_cnt <= TICK_LOAD;
                     hold_cnt <= hold_q;
                  end else begin
                     ph      <= ph + 1'b1;
                     contact <= ~contact;
                     cnt     <= BP_LOAD;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            HOLD: begin
               if (abort) begin
                  state   <= GAP;
                  contact <= 1'b0;
                  cnt     <= GAP_LOAD;
               end else if (tick_cnt == '0) begin
                  if (hold_cnt == 16'd0) begin
                     contact <= 1'b0;
                     ph      <= '0;
                     if (BOUNCE_TOGGLES > 0) begin
                        state <= BOUNCE_OUT;
                        cnt   <= BP_LOAD;
                     end else begin
                        state <= GAP;
                        cnt   <= GAP_LOAD;
                     end
                  end else begin
                     hold_cnt <= hold_cnt - 16'd1;
                     tick_cnt <= TICK_LOAD;
                  end
               end else begin
                  tick_cnt <= tick_cnt - 1'b1;
               end
            end
            BOUNCE_OUT: begin
               if (abort || (cnt == '0 && ph == PH_END)) begin
                  state   <= GAP;
                  contact <= 1'b0;
                  cnt     <= GAP_LOAD;
               end else if (cnt == '0) begin
                  ph      <= ph + 1'b1;
                  contact <= ~contact;
                  cnt     <= BP_LOAD;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            GAP: begin
               if (cnt == '0) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: begin
               state   <= IDLE;
               busy    <= 1'b0;
               contact <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready = rst && (state == IDLE);
   assign pressed   = contact;

   // Row sense follows the scanner's column drive with no clock delay.
   always_comb begin
      keypad_row = 4'b1111;
      if (contact && !keypad_col[key_q[3:2]])
         keypad_row[key_q[1:0]] = 1'b0;
   end

endmodule

// File: tb/tb_keypad_emulator.sv
// Bench for keypad_emulator: two instances (clean and bouncing contact) driven by
// shared directed and random stimulus, checked every cycle against a timeline model.
module tb_keypad_emulator;

   localparam int TICK = 4;
   localparam int GAPC = 8;
   localparam int BP   = 2;
   localparam int TOG1 = 2;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic [3:0]  req_key;
   logic [15:0] req_hold;
   logic        abort;
   logic [3:0]  col;
   logic [1:0]  rdy, prs, bsy, dn;
   logic [3:0]  row [2];

   int checks = 0;
   int errors = 0;

   keypad_emulator #(.TICK_DIV(TICK), .GAP_CYCLES(GAPC), .BOUNCE_PERIOD(BP), .BOUNCE_TOGGLES(0)) dut0 (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[0]), .req_key(req_key),
      .req_hold(req_hold), .abort(abort), .keypad_col(col), .keypad_row(row[0]),
      .pressed(prs[0]), .busy(bsy[0]), .done(dn[0]));

   keypad_emulator #(.TICK_DIV(TICK), .GAP_CYCLES(GAPC), .BOUNCE_PERIOD(BP), .BOUNCE_TOGGLES(TOG1)) dut1 (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[1]), .req_key(req_key),
      .req_hold(req_hold), .abort(abort), .keypad_col(col), .keypad_row(row[1]),
      .pressed(prs[1]), .busy(bsy[1]), .done(dn[1]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int inst, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s inst%0d t=%0t got=%0h expected=%0h", name, inst, $time, got, exp);
      end
   endtask

   function automatic logic [3:0] matrix_row(input bit closed, input logic [3:0] key, input logic [3:0] c);
      logic [3:0] r;
      r = 4'b1111;
      if (closed && c[key[3:2]] == 1'b0) r[key[1:0]] = 1'b0;
      return r;
   endfunction

   // Model: on acceptance, the whole contact timeline of the press is laid out
   // cycle by cycle; an abort replaces the rest of the contact part with a full gap.
   bit         tl [2][4096];
   int         m_pos [2];
   int         m_len [2];
   int         m_gap [2];
   bit         m_active [2];
   bit         m_done [2];
   logic [3:0] m_key [2];

   initial begin
      for (int i = 0; i < 2; i++) begin
         m_active[i] = 0; m_done[i] = 0; m_key[i] = 4'd0;
         m_pos[i] = 0; m_len[i] = 0; m_gap[i] = 0;
      end
      forever begin
         @(posedge clk or negedge rst);
         for (int i = 0; i < 2; i++) begin
            if (!rst) begin
               m_active[i] = 0;
               m_done[i]   = 0;
            end else begin
               bit nd;
               nd = 0;
               if (m_active[i]) begin
                  if (abort && m_pos[i] < m_gap[i]) begin
                     m_gap[i] = m_pos[i] + 1;
                     m_len[i] = m_gap[i] + GAPC;
                     for (int k = m_gap[i]; k < m_len[i]; k++) tl[i][k] = 0;
                  end
                  m_pos[i]++;
                  if (m_pos[i] == m_len[i]) begin
                     m_active[i] = 0;
                     nd = 1;
                  end
               end else if (req_valid) begin
                  int idx, tog, n;
                  tog = (i == 0) ? 0 : TOG1;
                  idx = 0;
                  for (int p = 0; p < 2 * tog; p++)
                     for (int j = 0; j < BP; j++) begin tl[i][idx] = (p % 2 == 0); idx++; end
                  n = ((req_hold == 16'd0) ? 1 : int'(req_hold)) * TICK;
                  for (int j = 0; j < n; j++) begin tl[i][idx] = 1; idx++; end
                  for (int p = 0; p < 2 * tog; p++)
                     for (int j = 0; j < BP; j++) begin tl[i][idx] = (p % 2 == 1); idx++; end
                  m_gap[i] = idx;
                  for (int j = 0; j < GAPC; j++) begin tl[i][idx] = 0; idx++; end
                  m_len[i]    = idx;
                  m_pos[i]    = 0;
                  m_key[i]    = req_key;
                  m_active[i] = 1;
               end
               m_done[i] = nd;
            end
         end
      end
   end

   // Every-cycle comparison of both instances against the model.
   initial begin
      forever begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            bit ep;
            ep = m_active[i] ? tl[i][m_pos[i]] : 1'b0;
            check("pressed", i, 32'(prs[i]), 32'(ep));
            check("busy", i, 32'(bsy[i]), 32'(m_active[i]));
            check("done", i, 32'(dn[i]), 32'(m_done[i]));
            check("req_ready", i, 32'(rdy[i]), 32'(rst && !m_active[i]));
            check("keypad_row", i, 32'(row[i]), 32'(matrix_row(ep, m_key[i], col)));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((bsy !== 2'b00 || dn !== 2'b00) && n < 2000) begin
         step();
         n++;
      end
      if (n >= 2000) begin
         errors++;
         $display("FAIL wait_idle timeout busy=%b", bsy);
      end
      step();
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int pc, bc, d0, d1;
      logic [27:0] cap;
      rst = 1'b0; req_valid = 1'b0; req_key = 4'd0; req_hold = 16'd0; abort = 1'b0; col = 4'hF;
      step(); step();
      check("reset_ready", 0, 32'(rdy[0]), 32'd0);
      check("reset_row", 0, 32'(row[0]), 32'hF);
      rst = 1'b1;
      #1;
      check("release_ready", 0, 32'(rdy[0]), 32'd1);
      step();

      // Key 6, hold 3 on the clean instance.
      req_valid = 1'b1; req_key = 4'd6; req_hold = 16'd3;
      step();
      req_valid = 1'b0;
      pc = 0; bc = 0; d0 = 0;
      for (int n = 1; n <= 25; n++) begin
         col = (n == 3) ? 4'b1101 : (n == 4) ? 4'b1110 : (n == 5) ? 4'b0000 : 4'b1111;
         @(negedge clk);
         if (prs[0]) pc++;
         if (bsy[0]) bc++;
         if (dn[0]) d0 = n;
         if (n == 3) check("row_col1101", 0, 32'(row[0]), 32'b1011);
         if (n == 4) check("row_col1110", 0, 32'(row[0]), 32'b1111);
         if (n == 5) check("row_col0000", 0, 32'(row[0]), 32'b1011);
         step();
      end
      check("press_cycles", 0, pc, 12);
      check("busy_cycles", 0, bc, 20);
      check("done_cycle", 0, d0, 21);
      col = 4'hF;
      wait_idle();

      // Key 0, hold 1: bounce pattern on the bouncing instance.
      req_valid = 1'b1; req_key = 4'd0; req_hold = 16'd1;
      step();
      req_valid = 1'b0;
      cap = '0; d0 = 0; d1 = 0;
      for (int n = 1; n <= 30; n++) begin
         @(negedge clk);
         if (n <= 28) cap = {cap[26:0], prs[1]};
         if (dn[0]) d0 = n;
         if (dn[1]) d1 = n;
         step();
      end
      check("bounce_pattern", 1, 32'(cap), 32'(28'hCCF3300));
      check("bounce_done", 1, d1, 29);
      check("hold1_done", 0, d0, 13);
      wait_idle();

      // Key 15, hold 100, abort during the 10th cycle.
      req_valid = 1'b1; req_key = 4'd15; req_hold = 16'd100; col = 4'b0111;
      step();
      req_valid = 1'b0;
      d0 = 0; d1 = 0;
      for (int n = 1; n <= 22; n++) begin
         abort = (n == 10);
         @(negedge clk);
         if (n == 10) begin
            check("abort_pre_pressed", 0, 32'(prs[0]), 32'd1);
            check("abort_pre_row", 0, 32'(row[0]), 32'b0111);
         end
         if (n == 11) begin
            check("abort_post_pressed", 0, 32'(prs[0]), 32'd0);
            check("abort_post_row", 0, 32'(row[0]), 32'b1111);
         end
         if (dn[0]) d0 = n;
         if (dn[1]) d1 = n;
         step();
      end
      abort = 1'b0;
      check("abort_done", 0, d0, 19);
      check("abort_done", 1, d1, 19);
      col = 4'hF;
      wait_idle();

      // Hold 0 with req_valid held: second acceptance in the done cycle.
      req_valid = 1'b1; req_key = 4'd5; req_hold = 16'd0;
      step();
      pc = 0; d0 = 0;
      for (int n = 1; n <= 14; n++) begin
         @(negedge clk);
         if (n <= 13 && prs[0]) pc++;
         if (dn[0] && d0 == 0) d0 = n;
         if (n == 14) check("b2b_pressed", 0, 32'(prs[0]), 32'd1);
         step();
      end
      req_valid = 1'b0;
      check("hold0_cycles", 0, pc, 4);
      check("b2b_done", 0, d0, 13);
      wait_idle();

      // Reset in the middle of HOLD with all columns driven.
      req_valid = 1'b1; req_key = 4'd2; req_hold = 16'd10; col = 4'b0000;
      step();
      req_valid = 1'b0;
      for (int n = 1; n <= 4; n++) step();
      check("pre_reset_row", 0, 32'(row[0]), 32'b1011);
      rst = 1'b0;
      #1;
      check("rst_row", 0, 32'(row[0]), 32'hF);
      check("rst_busy", 0, 32'(bsy[0]), 32'd0);
      check("rst_pressed", 0, 32'(prs[0]), 32'd0);
      check("rst_ready", 0, 32'(rdy[0]), 32'd0);
      step(); step();
      rst = 1'b1;
      #1;
      check("post_rst_ready", 0, 32'(rdy[0]), 32'd1);
      d0 = 0;
      for (int n = 0; n < 60; n++) begin
         @(negedge clk);
         if (dn !== 2'b00) d0++;
         step();
      end
      check("no_done_after_rst", 0, d0, 0);

      // Random traffic.
      for (int n = 0; n < 3000; n++) begin
         rst       = ($urandom_range(699) != 0);
         req_valid = ($urandom_range(2) == 0);
         req_key   = 4'($urandom);
         req_hold  = 16'($urandom_range(6));
         abort     = ($urandom_range(39) == 0);
         col       = 4'($urandom);
         step();
      end
      rst = 1'b1; req_valid = 1'b0; abort = 1'b0;
      wait_idle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
